hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
// Drives the Enable (stall, 1 = hold) and rst (flush, 1 = bubble) inputs of the four
//   pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
// Detects load-use hazards, taken branches/jumps resolved in EX, and data-memory waits.
// Runs the syscall-halt state machine.
// Keeps saturating performance counters for the debug display.
// PARAMETERS
// CNT_W     32   width of cyc_count / stall_count / flush_count
// PORTS
// clk            in   1      clock
// rst            in   1      synchronous, active-high reset
// id_rs_no       in   5      rs number of instruction in ID
// id_rt_no       in   5      rt number of instruction in ID
// id_uses_rs     in   1      ID instruction reads rs
// id_uses_rt     in   1      ID instruction reads rt
// ex_effective   in   1      ID/EX holds a valid instruction
// ex_memread     in   1      instruction in EX is a load
// ex_rd_no       in   5      destination register of instruction in EX
// ex_branch_taken in  1      branch/jump in EX resolved taken (valid when ex_effective)
// dmem_busy      in   1      data memory needs another cycle for the access in MEM
// wb_effective   in   1      MEM/WB Effective output
// wb_halt        in   1      MEM/WB holds a halting syscall ($v0 == 10)
// resume         in   1      single-cycle pulse from the board: leave HALT
// pc_stall       out  1      1 = PC holds
// ifid_stall, idex_stall, exmem_stall, memwb_stall  out 1 each  -> Enable of each reg
// ifid_flush, idex_flush, exmem_flush, memwb_flush  out 1 each  -> rst of each reg
// halted         out  1      registered; 1 while state == HALT
// cyc_count      out  CNT_W  cycles spent in RUN
// stall_count    out  CNT_W  load-use bubbles inserted
// flush_count    out  CNT_W  cycles in which a branch flush was applied
// BEHAVIOUR
// - FSM states: RUN, HALT. State, halted and counters are registered; stall/flush outputs
//   are combinational from inputs and state (they act on the same clock edge).
// - Reset cycle (rst=1): all *_stall = 0, all *_flush = 1. Next state = RUN,
//   halted = 0, all counters = 0.
// - Hazard conditions (rst=0):
//   H = RUN & wb_effective & wb_halt
//   M = dmem_busy
//   B = ex_effective & ex_branch_taken
//   L = ex_effective & ex_memread & ex_rd_no != 0 & ((id_uses_rs & id_rs_no == ex_rd_no)
//       | (id_uses_rt & id_rt_no == ex_rd_no))
// - Priority: HALT state / H > M > B > L > none. Only the winning action is applied.
//   - state == HALT or H: all five stalls = 1, all flushes = 0.
//     H sets next state = HALT.
//   - M: pc, ifid, idex, exmem stall = 1; memwb_flush = 1; other flushes = 0.
//     A taken branch in EX is held and acted on the first cycle M drops.
//   - B: ifid_flush = idex_flush = 1; no stalls. PC loads the branch target
//     (the PC mux is driven outside this block).
//     Wins over a coincident L, since the ID instruction is wrong-path.
//   - L: pc_stall = ifid_stall = 1; idex_flush = 1 (one bubble). Other outputs 0.
//     Cleared the following cycle because the load has moved to MEM.
//   - none: all stalls and flushes = 0.
// - HALT: resume = 1 -> next state = RUN. In that same cycle all stalls stay 1, and
//   memwb_flush = 1 so the syscall is not re-seen.
//   resume while in RUN is ignored. rst while in HALT -> RUN.
// - Counters saturate at all-ones, never wrap:
//   - cyc_count increments every non-reset cycle with state == RUN.
//   - stall_count increments on each cycle action L is applied.
//   - flush_count increments on each cycle action B is applied.
// - Register 0 never creates a load-use hazard. ex_effective = 0 suppresses B and L.
// TESTING
// 1 rst=1 for 2 cycles -> all flushes 1, stalls 0; then halted=0, counters=0.
// 2 EX lw rd=8; ID add rs=8 uses_rs=1 -> one cycle pc/ifid stall=1, idex_flush=1,
//   stall_count 0->1. Next cycle all 0. Repeat with rd=0 -> no stall.
// 3 Same load-use plus ex_branch_taken=1 -> ifid/idex flush=1, no stalls,
//   flush_count+1, stall_count unchanged.
// 4 dmem_busy=1 for 3 cycles with branch taken in EX -> 3 cycles of freeze with
//   memwb_flush=1; then one B cycle.
// 5 wb_effective=wb_halt=1 -> all stalls=1 that cycle. halted=1 next cycle,
//   cyc_count frozen. resume pulse -> memwb_flush=1, then RUN, halted=0.
// 6 Force cyc_count to 2^CNT_W-1 (CNT_W=4 build: run 20 cycles) -> holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall/flush control, syscall-halt FSM and perf counters
module hazard_ctrl_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_no,
    input  logic [4:0]       id_rt_no,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_effective,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd_no,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    input  logic             wb_effective,
    input  logic             wb_halt,
    input  logic             resume,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             memwb_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       hit_h;
    logic       hit_m;
    logic       hit_b;
    logic       hit_l;
    logic       apply_b;
    logic       apply_l;

    assign hit_h = (state == ST_RUN) && wb_effective && wb_halt;
    assign hit_m = dmem_busy;
    assign hit_b = ex_effective && ex_branch_taken;
    // $zero is never really written, so a load targeting it cannot cause a hazard
    assign hit_l = ex_effective && ex_memread && (ex_rd_no != 5'd0) &&
                   ((id_uses_rs && (id_rs_no == ex_rd_no)) ||
                    (id_uses_rt && (id_rt_no == ex_rd_no)));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        apply_b     = 1'b0;
        apply_l     = 1'b0;
        state_nxt   = state;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_nxt   = ST_RUN;
        end else if (state == ST_HALT || hit_h) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
            if (state == ST_RUN) begin
                state_nxt = ST_HALT;
            end else if (resume) begin
                // drop the syscall from MEM/WB so it does not halt us again
                memwb_flush = 1'b1;
                state_nxt   = ST_RUN;
            end
        end else if (hit_m) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (hit_b) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            apply_b    = 1'b1;
        end else if (hit_l) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            apply_l    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            cyc_count   <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == ST_HALT);
            if (state == ST_RUN && cyc_count != CNT_MAX)
                cyc_count <= cyc_count + CNT_W'(1);
            if (apply_l && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
            if (apply_b && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed and randomized check of hazard_ctrl_unit against a reference model
module tb_hazard_ctrl_unit;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [4:0] id_rs_no, id_rt_no, ex_rd_no;
    logic id_uses_rs, id_uses_rt, ex_effective, ex_memread, ex_branch_taken;
    logic dmem_busy, wb_effective, wb_halt, resume;
    logic pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [CNT_W-1:0] cyc_count, stall_count, flush_count;

    hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs_no(id_rs_no), .id_rt_no(id_rt_no),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_effective(ex_effective), .ex_memread(ex_memread), .ex_rd_no(ex_rd_no),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .wb_effective(wb_effective), .wb_halt(wb_halt), .resume(resume),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halted(halted), .cyc_count(cyc_count),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    int total = 0;
    int bad   = 0;

    bit m_halt  = 1'b0;
    int m_cyc   = 0;
    int m_stall = 0;
    int m_flush = 0;

    // actions: 0 none, 1 load-use, 2 branch, 3 mem wait, 4 halt detect, 5 in HALT, 6 reset
    typedef enum int {A_NONE, A_L, A_B, A_M, A_H, A_HALTED, A_RST} act_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic act_t pick_action();
        bit use_hit;
        if (rst) return A_RST;
        if (m_halt) return A_HALTED;
        if (wb_effective && wb_halt) return A_H;
        if (dmem_busy) return A_M;
        if (ex_effective && ex_branch_taken) return A_B;
        use_hit = (id_uses_rs && id_rs_no == ex_rd_no) || (id_uses_rt && id_rt_no == ex_rd_no);
        if (ex_effective && ex_memread && ex_rd_no != 0 && use_hit) return A_L;
        return A_NONE;
    endfunction

    // {pc,ifid,idex,exmem,memwb stall, ifid,idex,exmem,memwb flush}
    function automatic logic [8:0] expect_ctl(input act_t a);
        case (a)
            A_RST:    return 9'b00000_1111;
            A_HALTED: return resume ? 9'b11111_0001 : 9'b11111_0000;
            A_H:      return 9'b11111_0000;
            A_M:      return 9'b11110_0001;
            A_B:      return 9'b00000_1100;
            A_L:      return 9'b11000_0100;
            default:  return 9'b00000_0000;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic tick();
        act_t a;
        @(negedge clk);
        a = pick_action();
        check("ctl", 32'({pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                          ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(expect_ctl(a)));
        @(posedge clk);
        if (a == A_RST) begin
            m_halt = 1'b0; m_cyc = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!m_halt) m_cyc = sat_inc(m_cyc);
            if (a == A_L) m_stall = sat_inc(m_stall);
            if (a == A_B) m_flush = sat_inc(m_flush);
            if (a == A_HALTED && resume) m_halt = 1'b0;
            else if (a == A_H) m_halt = 1'b1;
        end
        #1;
        check("halted", 32'(halted), 32'(m_halt));
        check("cyc_count", 32'(cyc_count), 32'(m_cyc));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        check("flush_count", 32'(flush_count), 32'(m_flush));
    endtask

    task automatic set_idle();
        rst = 1'b0; id_rs_no = '0; id_rt_no = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_effective = 1'b0; ex_memread = 1'b0; ex_rd_no = '0; ex_branch_taken = 1'b0;
        dmem_busy = 1'b0; wb_effective = 1'b0; wb_halt = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        do_reset();
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_cyc", 32'(cyc_count), 32'd0);

        // load-use on rs, then cleared, then with $zero as destination
        ex_effective = 1'b1; ex_memread = 1'b1; ex_rd_no = 5'd8;
        id_rs_no = 5'd8; id_uses_rs = 1'b1;
        tick();
        check("lu_stall_count", 32'(stall_count), 32'd1);
        ex_memread = 1'b0;
        tick();
        ex_memread = 1'b1; ex_rd_no = 5'd0; id_rs_no = 5'd0;
        tick();
        check("lu_r0_stall_count", 32'(stall_count), 32'd1);

        // load-use on rt coinciding with a taken branch: branch wins
        ex_rd_no = 5'd9; id_rt_no = 5'd9; id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
        tick();
        check("b_over_l_flush", 32'(flush_count), 32'd1);
        check("b_over_l_stall", 32'(stall_count), 32'd1);

        // memory wait holding a taken branch, then the branch acts
        set_idle();
        ex_effective = 1'b1; ex_branch_taken = 1'b1; dmem_busy = 1'b1;
        repeat (3) tick();
        dmem_busy = 1'b0;
        tick();
        check("m_then_b_flush", 32'(flush_count), 32'd2);

        // syscall halt, idle in HALT, resume pulse
        set_idle();
        wb_effective = 1'b1; wb_halt = 1'b1;
        tick();
        check("halt_entered", 32'(halted), 32'd1);
        repeat (3) tick();
        set_idle();
        resume = 1'b1;
        tick();
        check("halt_left", 32'(halted), 32'd0);
        resume = 1'b0;
        tick();

        // counter saturation
        do_reset();
        repeat (20) tick();
        check("cyc_saturated", 32'(cyc_count), 32'(SAT));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            id_rs_no        = 5'($urandom_range(0, 3));
            id_rt_no        = 5'($urandom_range(0, 3));
            ex_rd_no        = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom);
            id_uses_rt      = 1'($urandom);
            ex_effective    = ($urandom_range(0, 3) != 0);
            ex_memread      = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            dmem_busy       = ($urandom_range(0, 4) == 0);
            wb_effective    = 1'($urandom);
            wb_halt         = ($urandom_range(0, 9) == 0);
            resume          = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
